queen_mem_arbiter: RTL and testbench



---
 rtl/queen_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_queen_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_mem_arbiter.sv
// ---------------------------------------------------------------------------
// queen_mem_arbiter
//
// Owns the N-entry queen-position memory (entry c = row of the queen in
// column c) and arbitrates its single port between the eight-queen solver
// (requester S) and a host readout/debug port (requester H).
//
// Arbitration is round-robin with a bounded burst length. The solver may
// assert s_lock to keep ownership across a backtrack sequence so that host
// accesses never interleave with it.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_clr             clears every entry to 0 at the next edge
//   s_req, s_lock       solver request / ownership lock
//   s_we, s_addr,
//   s_wdata             solver access (write when s_we=1, else read)
//   s_gnt               solver owns the memory
//   s_rdata, s_rvalid   solver read data, valid one cycle after the read
//   h_req               host request
//   h_we, h_addr,
//   h_wdata             host access
//   h_gnt               host owns the memory
//   h_rdata, h_rvalid   host read data, valid one cycle after the read
// ---------------------------------------------------------------------------
module queen_mem_arbiter #(
  parameter int N         = 8,
  parameter int AW        = 3,
  parameter int RW        = 3,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_clr,
  input  logic          s_req,
  input  logic          s_lock,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [RW-1:0] s_wdata,
  output logic          s_gnt,
  output logic [RW-1:0] s_rdata,
  output logic          s_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [RW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [RW-1:0] h_rdata,
  output logic          h_rvalid
);

  typedef enum logic [1:0] {
    IDLE,
    S_OWN,
    H_OWN
  } state_t;

  localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [AW:0]   N_LIM      = (AW + 1)'(N);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] burst_cnt;
  logic          last_was_s;
  logic [RW-1:0] mem [N];

  logic          s_want;
  logic          s_acc;
  logic          h_acc;
  logic          burst_last;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [RW-1:0] acc_wdata;
  logic          addr_ok;
  logic [RW-1:0] rd_data;

  // A held lock counts as an S request even while s_req is low; only an
  // owner with its req high performs an access.
  assign s_want     = s_req | s_lock;
  assign s_acc      = (state == S_OWN) & s_req;
  assign h_acc      = (state == H_OWN) & h_req;
  assign burst_last = (burst_cnt == BURST_LAST);

  assign s_gnt = (state == S_OWN);
  assign h_gnt = (state == H_OWN);

  // Next-owner selection. From IDLE a tie goes to whoever did not own last;
  // owner-to-owner handoff is direct so it costs no bubble cycle. The burst
  // limit only forces a handoff on the access that reaches it, and the
  // solver lock suppresses it entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_want && h_req) state_nxt = last_was_s ? H_OWN : S_OWN;
        else if (s_want)     state_nxt = S_OWN;
        else if (h_req)      state_nxt = H_OWN;
      end
      S_OWN: begin
        if (!s_want)
          state_nxt = h_req ? H_OWN : IDLE;
        else if (s_acc && burst_last && h_req && !s_lock)
          state_nxt = H_OWN;
      end
      H_OWN: begin
        if (!h_req)
          state_nxt = s_want ? S_OWN : IDLE;
        else if (h_acc && burst_last && s_want)
          state_nxt = S_OWN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership register with burst counter and round-robin memory. The
  // counter restarts on every ownership change and saturates otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_was_s <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        burst_cnt <= '0;
        if (state != IDLE) last_was_s <= (state == S_OWN);
      end else if ((s_acc || h_acc) && !burst_last) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // Port mux: the non-owner's inputs never reach the memory.
  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (s_acc) begin
      acc_we    = s_we;
      acc_addr  = s_addr;
      acc_wdata = s_wdata;
    end else if (h_acc) begin
      acc_we    = h_we;
      acc_addr  = h_addr;
      acc_wdata = h_wdata;
    end
  end

  assign addr_ok = ({1'b0, acc_addr} < N_LIM);
  assign rd_data = addr_ok ? mem[acc_addr] : '0;

  // Memory array. A clear wins over a same-cycle write; a same-cycle read
  // still sees the old contents because it samples before the edge.
  always_ff @(posedge clk) begin
    if (rst || mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if ((s_acc || h_acc) && acc_we && addr_ok) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // Read return registers: data holds until the next read by that side,
  // valid is a single-cycle pulse per read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rdata  <= '0;
      s_rvalid <= 1'b0;
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
    end else begin
      s_rvalid <= s_acc && !s_we;
      h_rvalid <= h_acc && !h_we;
      if (s_acc && !s_we) s_rdata <= rd_data;
      if (h_acc && !h_we) h_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_queen_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queen_mem_arbiter
//
// Self-checking bench for queen_mem_arbiter. Inputs change on the falling
// edge; a behavioural model (owner as a number, accesses per tenure, plain
// integer memory) predicts the outputs that follow the next rising edge and
// every output is compared on the following falling edge. Directed scenarios
// also pin selected outputs to hand-computed constants, then a long
// randomized run exercises the rest.
// ---------------------------------------------------------------------------
module tb_queen_mem_arbiter;

  localparam int N         = 8;
  localparam int AW        = 3;
  localparam int RW        = 3;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          rst;
  logic          mem_clr;
  logic          s_req;
  logic          s_lock;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [RW-1:0] s_wdata;
  logic          s_gnt;
  logic [RW-1:0] s_rdata;
  logic          s_rvalid;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [RW-1:0] h_wdata;
  logic          h_gnt;
  logic [RW-1:0] h_rdata;
  logic          h_rvalid;

  int checks;
  int errors;

  // Model: owner 0 = nobody, 1 = solver, 2 = host.
  int m_owner;
  int m_tenure;
  int m_last;
  int m_mem [N];
  int m_s_rdata;
  int m_s_rv;
  int m_h_rdata;
  int m_h_rv;

  queen_mem_arbiter #(
    .N(N), .AW(AW), .RW(RW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .mem_clr(mem_clr),
    .s_req(s_req), .s_lock(s_lock), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_gnt(s_gnt), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One named comparison; every check in the bench goes through here.
  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic modelStep();
    bit s_want;
    bit s_acc;
    bit h_acc;
    bit at_limit;
    int nxt;
    if (rst) begin
      m_owner = 0; m_tenure = 0; m_last = 2;
      for (int i = 0; i < N; i++) m_mem[i] = 0;
      m_s_rdata = 0; m_s_rv = 0; m_h_rdata = 0; m_h_rv = 0;
      return;
    end
    s_want   = s_req || s_lock;
    s_acc    = (m_owner == 1) && s_req;
    h_acc    = (m_owner == 2) && h_req;
    at_limit = (m_tenure + 1 >= MAX_BURST);

    m_s_rv = (s_acc && !s_we) ? 1 : 0;
    m_h_rv = (h_acc && !h_we) ? 1 : 0;
    if (m_s_rv == 1) m_s_rdata = m_mem[s_addr];
    if (m_h_rv == 1) m_h_rdata = m_mem[h_addr];

    if (mem_clr) begin
      for (int i = 0; i < N; i++) m_mem[i] = 0;
    end else if (s_acc && s_we) begin
      m_mem[s_addr] = int'(s_wdata);
    end else if (h_acc && h_we) begin
      m_mem[h_addr] = int'(h_wdata);
    end

    nxt = m_owner;
    if (m_owner == 0) begin
      if (s_want && h_req) nxt = (m_last == 1) ? 2 : 1;
      else if (s_want)     nxt = 1;
      else if (h_req)      nxt = 2;
    end else if (m_owner == 1) begin
      if (!s_want) nxt = h_req ? 2 : 0;
      else if (s_acc && at_limit && h_req && !s_lock) nxt = 2;
    end else begin
      if (!h_req) nxt = s_want ? 1 : 0;
      else if (h_acc && at_limit && s_want) nxt = 1;
    end

    if (nxt != m_owner) begin
      if (m_owner != 0) m_last = m_owner;
      m_tenure = 0;
    end else if (s_acc || h_acc) begin
      m_tenure++;
    end
    m_owner = nxt;
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    checkValue("s_gnt",    int'(s_gnt),    (m_owner == 1) ? 1 : 0);
    checkValue("h_gnt",    int'(h_gnt),    (m_owner == 2) ? 1 : 0);
    checkValue("gnt_excl", int'(s_gnt && h_gnt), 0);
    checkValue("s_rvalid", int'(s_rvalid), m_s_rv);
    checkValue("h_rvalid", int'(h_rvalid), m_h_rv);
    checkValue("s_rdata",  int'(s_rdata),  m_s_rdata);
    checkValue("h_rdata",  int'(h_rdata),  m_h_rdata);
  endtask

  // Inputs are already driven; let one edge happen, then compare.
  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic quietInputs();
    rst = 1'b0; mem_clr = 1'b0;
    s_req = 1'b0; s_lock = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
  endtask

  int exp_owner [8] = '{1, 1, 1, 2, 2, 2, 2, 1};

  initial begin
    checks = 0;
    errors = 0;
    quietInputs();

    // Reset held two cycles with both sides requesting.
    rst = 1'b1; s_req = 1'b1; h_req = 1'b1;
    applyStimulus();
    checkValue("rst_s_gnt", int'(s_gnt), 0);
    applyStimulus();
    rst = 1'b0;
    checkValue("rel_s_gnt",    int'(s_gnt),    0);
    checkValue("rel_h_gnt",    int'(h_gnt),    0);
    checkValue("rel_s_rvalid", int'(s_rvalid), 0);
    checkValue("rel_h_rdata",  int'(h_rdata),  0);

    // Tie from IDLE: S wins first, then bursts of four alternate.
    applyStimulus();
    checkValue("tie_first_s", int'(s_gnt), 1);
    for (int i = 0; i < 8; i++) begin
      s_addr = 3'(i); h_addr = 3'(7 - i);
      applyStimulus();
      checkValue("tie_owner", s_gnt ? 1 : (h_gnt ? 2 : 0), exp_owner[i]);
    end

    // Solver write then read of column 3.
    h_req = 1'b0; s_we = 1'b1; s_addr = 3'd3; s_wdata = 3'd5;
    applyStimulus();
    checkValue("wr_s_rvalid", int'(s_rvalid), 0);
    s_we = 1'b0;
    applyStimulus();
    checkValue("rd_s_rvalid", int'(s_rvalid), 1);
    checkValue("rd_s_rdata",  int'(s_rdata),  5);
    checkValue("rd_h_rvalid", int'(h_rvalid), 0);
    s_req = 1'b0; s_lock = 1'b1;
    applyStimulus();
    checkValue("rd_pulse_end", int'(s_rvalid), 0);

    // Lock holds ownership well past the burst limit.
    s_req = 1'b1; h_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_addr = 3'(i);
      applyStimulus();
      checkValue("lock_s_gnt", int'(s_gnt), 1);
    end
    s_req = 1'b0; s_lock = 1'b0;
    applyStimulus();
    checkValue("unlock_h_gnt", int'(h_gnt), 1);

    // Preload 1..7,0 then clear in the same cycle as a write.
    h_req = 1'b0; s_req = 1'b1;
    applyStimulus();
    checkValue("pre_s_gnt", int'(s_gnt), 1);
    s_we = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_addr = 3'(i); s_wdata = 3'((i + 1) % N);
      applyStimulus();
    end
    s_we = 1'b0; s_addr = 3'd4;
    applyStimulus();
    checkValue("preload_rd4", int'(s_rdata), 5);
    mem_clr = 1'b1; s_we = 1'b1; s_addr = 3'd2; s_wdata = 3'd6;
    applyStimulus();
    mem_clr = 1'b0; s_we = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_addr = 3'(i);
      applyStimulus();
      checkValue("clr_rd_rdata",  int'(s_rdata),  0);
      checkValue("clr_rd_rvalid", int'(s_rvalid), 1);
    end

    // Reset while the host owns with a read in flight.
    s_req = 1'b0; h_req = 1'b1;
    applyStimulus();
    checkValue("h_take", int'(h_gnt), 1);
    h_we = 1'b1; h_addr = 3'd3; h_wdata = 3'd7;
    applyStimulus();
    h_we = 1'b0;
    applyStimulus();
    checkValue("h_rd_pre_rst", int'(h_rdata), 7);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkValue("rst_mid_h_gnt",    int'(h_gnt),    0);
    checkValue("rst_mid_h_rvalid", int'(h_rvalid), 0);
    applyStimulus();
    checkValue("regrant_h_gnt", int'(h_gnt), 1);
    applyStimulus();
    checkValue("post_rst_rvalid", int'(h_rvalid), 1);
    checkValue("post_rst_rdata",  int'(h_rdata),  0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      mem_clr = ($urandom_range(0, 19) == 0);
      s_req   = ($urandom_range(0, 9) < 7);
      s_lock  = ($urandom_range(0, 4) == 0);
      s_we    = $urandom_range(0, 1) == 1;
      s_addr  = 3'($urandom_range(0, N - 1));
      s_wdata = 3'($urandom_range(0, N - 1));
      h_req   = ($urandom_range(0, 9) < 6);
      h_we    = $urandom_range(0, 1) == 1;
      h_addr  = 3'($urandom_range(0, N - 1));
      h_wdata = 3'($urandom_range(0, N - 1));
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
